// File: rtl/approx_mult_error_monitor.sv
// approx_mult_error_monitor: recomputes a*b with a sequential shift-add multiplier,
// measures the error distance against the multiplier-under-test result and keeps
// saturating error statistics.
module approx_mult_error_monitor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 20,
  parameter int unsigned SUM_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   s_apx,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   exact,
  output logic [2*WIDTH-1:0]   ed,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     error_count,
  output logic [2*WIDTH-1:0]   max_ed,
  output logic [SUM_W-1:0]     sum_ed
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SX     = SUM_W + 1;

  typedef enum logic [1:0] {IDLE, MUL, CMP} state_t;

  state_t            state;
  state_t            stateNext;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     sApxQ;
  logic [WIDTH-1:0]  mplier;
  logic [STEP_W-1:0] stepCnt;
  logic              accept;
  logic              lastStep;
  logic [PW-1:0]     edC;
  logic [SX-1:0]     sumExt;
  logic [SUM_W-1:0]  sumNext;

  // Handshake: clear outranks a new sample, so nothing is accepted on a clear edge
  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready && !clear;
  assign lastStep = (stepCnt == STEP_W'(WIDTH - 1));

  // Error distance and saturating accumulator sum, evaluated while in CMP
  always_comb begin
    edC     = (acc >= sApxQ) ? (acc - sApxQ) : (sApxQ - acc);
    sumExt  = {1'b0, sum_ed} + SX'(edC);
    sumNext = sumExt[SUM_W] ? {SUM_W{1'b1}} : sumExt[SUM_W-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic; clear abandons any in-flight sample
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = MUL;
      MUL:     if (lastStep) stateNext = CMP;
      CMP:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (clear) stateNext = IDLE;
  end

  // Shift-add datapath: multiplicand shifts left as the multiplier shifts right
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      sApxQ   <= '0;
      mplier  <= '0;
      stepCnt <= '0;
    end else if (accept) begin
      acc     <= '0;
      mcand   <= PW'(a);
      sApxQ   <= s_apx;
      mplier  <= b;
      stepCnt <= '0;
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      stepCnt <= stepCnt + STEP_W'(1);
    end
  end

  // Result registers and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      exact        <= '0;
      ed           <= '0;
      sample_count <= '0;
      error_count  <= '0;
      max_ed       <= '0;
      sum_ed       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        sample_count <= '0;
        error_count  <= '0;
        max_ed       <= '0;
        sum_ed       <= '0;
      end else if (state == CMP) begin
        out_valid <= 1'b1;
        exact     <= acc;
        ed        <= edC;
        if (!(&sample_count)) sample_count <= sample_count + CNT_W'(1);
        if ((edC != '0) && !(&error_count)) error_count <= error_count + CNT_W'(1);
        if (edC > max_ed) max_ed <= edC;
        sum_ed <= sumNext;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Scoreboard bench for approx_mult_error_monitor: a driver pushes expected results
// computed with plain arithmetic, a monitor pops and compares on each out_valid.
module tb_approx_mult_error_monitor;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned SUM_W = 40;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned SAT_MAX = 3;

  logic                 clk = 1'b0;
  logic                 rst, clear, in_valid;
  logic [WIDTH-1:0]     a, b;
  logic [2*WIDTH-1:0]   s_apx;
  logic                 in_ready, out_valid;
  logic [2*WIDTH-1:0]   exact, ed, max_ed;
  logic [CNT_W-1:0]     sample_count, error_count;
  logic [SUM_W-1:0]     sum_ed;

  logic                 in_ready2, out_valid2;
  logic [2*WIDTH-1:0]   exact2, ed2, max_ed2;
  logic [1:0]           sample_count2, error_count2;
  logic [SUM_W-1:0]     sum_ed2;

  approx_mult_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s_apx(s_apx), .out_valid(out_valid), .exact(exact), .ed(ed),
    .sample_count(sample_count), .error_count(error_count), .max_ed(max_ed), .sum_ed(sum_ed)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation
  approx_mult_error_monitor #(.WIDTH(WIDTH), .CNT_W(2), .SUM_W(SUM_W)) dutSat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .s_apx(s_apx), .out_valid(out_valid2), .exact(exact2), .ed(ed2),
    .sample_count(sample_count2), .error_count(error_count2), .max_ed(max_ed2), .sum_ed(sum_ed2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned       exact;
    int unsigned       ed;
    int unsigned       scnt;
    int unsigned       ecnt;
    int unsigned       maxEd;
    longint unsigned   sumEd;
    int                k;
  } exp_t;

  exp_t            q[$];
  int unsigned     mScnt, mEcnt, mMax;
  longint unsigned mSum;
  int              lastK;
  int              nVec = 0;
  int              nErr = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned expv);
    nVec++;
    if (act !== expv) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int unsigned satMin(input int unsigned v, input int unsigned m);
    return (v > m) ? m : v;
  endfunction

  task automatic modelZero();
    q.delete();
    mScnt = 0; mEcnt = 0; mMax = 0; mSum = 0;
  endtask

  // Present a sample from a negedge, wait for acceptance, record the expectation
  task automatic send(input int unsigned av, input int unsigned bv, input int unsigned sv);
    exp_t e;
    bit   rdy;
    int   n = 0;
    a = WIDTH'(av); b = WIDTH'(bv); s_apx = (2*WIDTH)'(sv);
    in_valid = 1'b1;
    forever begin
      rdy = in_ready;
      e.k = cyc + 1;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    lastK   = e.k;
    e.exact = av * bv;
    e.ed    = (e.exact >= sv) ? e.exact - sv : sv - e.exact;
    mScnt   = satMin(mScnt + 1, CNT_MAX);
    if (e.ed != 0) mEcnt = satMin(mEcnt + 1, CNT_MAX);
    if (e.ed > mMax) mMax = e.ed;
    mSum    = mSum + e.ed;
    e.scnt = mScnt; e.ecnt = mEcnt; e.maxEd = mMax; e.sumEd = mSum;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); s_apx = (2*WIDTH)'($urandom);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        chk("out_valid_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("latency", cyc, e.k + WIDTH + 1);
          chk("exact", exact, e.exact);
          chk("ed", ed, e.ed);
          chk("sample_count", sample_count, e.scnt);
          chk("error_count", error_count, e.ecnt);
          chk("max_ed", max_ed, e.maxEd);
          chk("sum_ed", sum_ed, e.sumEd);
          chk("sat_out_valid", out_valid2, 1);
          chk("sat_sample_count", sample_count2, satMin(e.scnt, SAT_MAX));
          chk("sat_error_count", error_count2, satMin(e.ecnt, SAT_MAX));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, ex, sv;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; a = '0; b = '0; s_apx = '0;
    modelZero();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sample_count", sample_count, 0);
    chk("rst_error_count", error_count, 0);
    chk("rst_max_ed", max_ed, 0);
    chk("rst_sum_ed", sum_ed, 0);
    chk("rst_exact", exact, 0);

    // Exact match, under/over errors
    send(255, 255, 65025);
    idle(WIDTH + 3);
    send(200, 100, 19975);
    send(0, 200, 3);
    idle(WIDTH + 3);
    chk("dir_error_count", error_count, 2);
    chk("dir_max_ed", max_ed, 25);
    chk("dir_sum_ed", sum_ed, 28);

    // Back-to-back with in_valid held high
    send(17, 3, 51);
    k0 = lastK;
    send(99, 201, 19900);
    chk("b2b_gap1", lastK - k0, WIDTH + 2);
    k0 = lastK;
    send(128, 2, 0);
    chk("b2b_gap2", lastK - k0, WIDTH + 2);
    idle(WIDTH + 3);
    chk("b2b_sample_count", sample_count, 6);

    // Clear mid-MUL
    send(123, 45, 5535);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    modelZero();
    @(negedge clk);
    clear = 1'b0;
    chk("clr_in_ready", in_ready, 1);
    chk("clr_sample_count", sample_count, 0);
    chk("clr_error_count", error_count, 0);
    chk("clr_max_ed", max_ed, 0);
    chk("clr_sum_ed", sum_ed, 0);
    chk("clr_keeps_exact", exact, 256);
    idle(WIDTH + 3);

    // Reset mid-CMP
    send(77, 66, 5000);
    in_valid = 1'b0;
    repeat (WIDTH) @(negedge clk);
    rst = 1'b1;
    modelZero();
    @(negedge clk);
    rst = 1'b0;
    chk("rstcmp_out_valid", out_valid, 0);
    chk("rstcmp_exact", exact, 0);
    chk("rstcmp_ed", ed, 0);
    chk("rstcmp_sample_count", sample_count, 0);
    idle(WIDTH + 3);

    // Five erroneous samples push the narrow counters into saturation
    for (int i = 0; i < 5; i++) send(10 + i, 20, 7);
    idle(WIDTH + 3);
    chk("sat5_sample_count", sample_count2, 3);
    chk("sat5_error_count", error_count2, 3);
    chk("sat5_wide_count", sample_count, 5);

    // Randomised samples: exact, near-miss and arbitrary results, random gaps
    for (int i = 0; i < 40; i++) begin
      int unsigned av, bv;
      av = $urandom_range(0, 255);
      bv = $urandom_range(0, 255);
      ex = int'(av * bv);
      case ($urandom_range(0, 2))
        0:       sv = ex;
        1:       sv = ex + int'($urandom_range(0, 300)) - 150;
        default: sv = int'($urandom_range(0, 65535));
      endcase
      if (sv < 0) sv = 0;
      if (sv > 65535) sv = 65535;
      send(av, bv, sv);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 12));
    end
    idle(WIDTH + 4);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
